// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the 7-segment scan driver: hex segment
//               table, all-off pattern, scan FSM state encoding and a width
//               helper for the slot counter and digit index.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    // The concatenation lists entry 15 first.
    localparam logic [15:0][6:0] c_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Active-high "nothing lit" pattern.
    localparam logic [6:0] c_SEG_OFF = 7'h00;

    // Scan FSM state encoding.
    localparam int              c_ST_W     = 1;
    localparam logic [c_ST_W-1:0] c_ST_BLANK = 1'b0;
    localparam logic [c_ST_W-1:0] c_ST_SHOW  = 1'b1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int seg7_clog2(input int n);
        int result;
        int v;
        result = 0;
        v      = n - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational hex nibble to active-high 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    // Straight table lookup; polarity is applied by the caller.
    assign o_pattern = c_SEG_TABLE[i_nibble];

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_mux
// Description : Time-multiplexed N-digit 7-segment driver. Scans digits
//               round-robin, blanks the start of every digit slot to stop
//               ghosting, decodes the frame snapshot nibble for the active
//               digit and registers seg/com. The packed value is captured
//               once per frame so a frame never mixes two values.
//               Optional build macro SEG7_LZ_BLANK_EN enables leading-zero
//               suppression (digit 0 is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int REFRESH_DIV    = 4096,
    parameter int BLANK_CYCLES   = 16,
    parameter bit COM_ACTIVE_LOW = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   com,
    output logic                    frame_start
);

    localparam int c_SLOT_W = seg7_clog2(REFRESH_DIV);
    localparam int c_IDX_W  = seg7_clog2(NUM_DIGITS);

    localparam logic [c_SLOT_W-1:0]   c_SLOT_LAST = c_SLOT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_DARK  = SEG_ACTIVE_LOW ? ~c_SEG_OFF : c_SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] c_COM_DARK  = COM_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};
    // With no blanking gap the very first slot cycle is already SHOW.
    localparam logic [c_ST_W-1:0]     c_ST_SLOT0  = (BLANK_CYCLES == 0) ? c_ST_SHOW : c_ST_BLANK;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [c_SLOT_W-1:0]     r_slot_cnt;
    logic [c_IDX_W-1:0]      r_digit_idx;
    logic [c_ST_W-1:0]       r_state;
    logic [4*NUM_DIGITS-1:0] r_snapshot;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_com;
    logic                    r_frame_start;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                    w_slot_wrap;
    logic [c_SLOT_W-1:0]     w_slot_next;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic [c_ST_W-1:0]       w_state_next;
    logic                    w_capture;
    logic [4*NUM_DIGITS-1:0] w_frame_data;
    logic [NUM_DIGITS-1:0]   w_idx_onehot;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [3:0]              w_nibble;
    logic [6:0]              w_pattern;
    logic                    w_digit_lit;
    logic [6:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_com_next;

    // ------------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------------
    assign w_slot_wrap = (r_slot_cnt == c_SLOT_LAST);
    assign w_slot_next = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    assign w_idx_next  = !w_slot_wrap              ? r_digit_idx :
                         (r_digit_idx == c_IDX_LAST) ? '0          :
                                                       r_digit_idx + 1'b1;

    // Advance the slot counter every cycle and the digit index on slot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else begin
            r_slot_cnt  <= w_slot_next;
            r_digit_idx <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------------
    // Scan FSM: r_state is the phase belonging to the current r_slot_cnt
    // ------------------------------------------------------------------------
    // Hold the phase of the current slot cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_SLOT0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leading cycles of each slot are BLANK, the rest SHOW.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_BLANK: begin
                if (int'(w_slot_next) >= BLANK_CYCLES) w_state_next = c_ST_SHOW;
            end
            c_ST_SHOW: begin
                if (int'(w_slot_next) < BLANK_CYCLES) w_state_next = c_ST_BLANK;
            end
            default: w_state_next = c_ST_SLOT0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame snapshot. The cycle at slot 0 of digit 0 uses the live value so
    // that frame's first displayed cycle already matches the new snapshot.
    // ------------------------------------------------------------------------
    assign w_capture    = (r_slot_cnt == '0) && (r_digit_idx == '0);
    assign w_frame_data = w_capture ? value : r_snapshot;

    // Capture the packed value once per frame, at the first cycle of digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snapshot <= '0;
        end else if (w_capture) begin
            r_snapshot <= value;
        end
    end

    // ------------------------------------------------------------------------
    // Digit select decode
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_idx_dec
        assign w_idx_onehot[gi] = (r_digit_idx == c_IDX_W'(gi));
    end

    // ------------------------------------------------------------------------
    // Leading-zero mask
    // ------------------------------------------------------------------------
`ifdef SEG7_LZ_BLANK_EN
    // Walk down from the top digit; a digit above 0 is dark while every
    // nibble from it upward is zero.
    always_comb begin : p_lz_mask
        logic v_zero_run;
        w_lz_blank = '0;
        v_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_zero_run    = v_zero_run && (w_frame_data[4*i +: 4] == 4'h0);
            w_lz_blank[i] = v_zero_run;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    // ------------------------------------------------------------------------
    // Nibble select and decode
    // ------------------------------------------------------------------------
    // Pick the nibble belonging to the active digit.
    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_onehot[i]) w_nibble = w_frame_data[4*i +: 4];
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    assign w_digit_lit = (r_state == c_ST_SHOW) &&
                         (|(w_idx_onehot & digit_en & ~w_lz_blank));

    // Drive the lit digit with board polarity; everything else stays dark.
    always_comb begin
        w_seg_next = c_SEG_DARK;
        w_com_next = c_COM_DARK;
        if (w_digit_lit) begin
            w_seg_next = SEG_ACTIVE_LOW ? ~w_pattern    : w_pattern;
            w_com_next = COM_ACTIVE_LOW ? ~w_idx_onehot : w_idx_onehot;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    // Register pins so they change glitch-free, one cycle after the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg         <= c_SEG_DARK;
            r_com         <= c_COM_DARK;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_next;
            r_com         <= w_com_next;
            r_frame_start <= w_capture;
        end
    end

    assign seg         = r_seg;
    assign com         = r_com;
    assign frame_start = r_frame_start;

endmodule : seg7_scan_mux
`default_nettype wire
